// File: rtl/store_merge_unit_if.sv
// Store request / data-memory bus shared by the control unit, the store merge engine and memory.
// The slave modport is the engine's view; the master modport is everything around it.
interface store_merge_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  start;
    logic [1:0]            store_size;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] b_out;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_valid;
    logic                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BYTES-1:0]      byte_enable;
    logic                  busy;
    logic                  done;
    logic                  misaligned;

    modport master (
        output start, store_size, address, b_out,
        output mem_rd_data, mem_rd_valid, mem_wr_ready,
        input  mem_address, mem_read, mem_write, mem_wr_data, byte_enable,
        input  busy, done, misaligned
    );

    modport slave (
        input  start, store_size, address, b_out,
        input  mem_rd_data, mem_rd_valid, mem_wr_ready,
        output mem_address, mem_read, mem_write, mem_wr_data, byte_enable,
        output busy, done, misaligned
    );
endinterface

// File: rtl/store_merge_unit.sv
// Sequenced store engine: sub-word stores do read / merge / write on the containing word,
// full-width stores write directly, misaligned stores complete at once with no memory traffic.
module store_merge_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    store_merge_unit_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] st_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BYTES-1:0]      be_q;
    logic [OFS-1:0]        ofs_q;
    logic                  mis_q;

    logic [OFS-1:0]        req_ofs;
    logic [BYTES-1:0]      req_be;
    logic                  req_mis;
    logic                  req_full;
    logic                  accept;

    function automatic int size_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    // A size wider than the memory word (double on a 32-bit bus) can never be aligned.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFS-1:0] o);
        int n;
        n = size_bytes(sz);
        if (n > BYTES) return 1'b1;
        return (int'(o) & (n - 1)) != 0;
    endfunction

    function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] sz, input logic [OFS-1:0] o);
        logic [BYTES-1:0] m;
        int n;
        n = size_bytes(sz);
        for (int k = 0; k < BYTES; k++) begin
            m[k] = (k >= int'(o)) && (k < int'(o) + n);
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] st,
                                                         input logic [DATA_WIDTH-1:0] rd,
                                                         input logic [BYTES-1:0]      be,
                                                         input logic [OFS-1:0]        o);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] w;
        sh = st << (8 * int'(o));
        for (int k = 0; k < BYTES; k++) begin
            w[8*k +: 8] = be[k] ? sh[8*k +: 8] : rd[8*k +: 8];
        end
        return w;
    endfunction

    always_comb begin
        req_ofs  = bus.address[OFS-1:0];
        req_mis  = is_misaligned(bus.store_size, req_ofs);
        req_full = (size_bytes(bus.store_size) == BYTES);
        req_be   = lane_mask(bus.store_size, req_ofs);
        accept   = (state == IDLE) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (req_mis)       state_nxt = DONE;
                    else if (req_full) state_nxt = WRITE;
                    else               state_nxt = READ;
                end
            end
            READ:    if (bus.mem_rd_valid) state_nxt = MERGE;
            MERGE:   state_nxt = WRITE;
            WRITE:   if (bus.mem_wr_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand and read-data holding registers; only consumed after being loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            st_q  <= bus.b_out;
            ofs_q <= req_ofs;
        end
        if (state == READ && bus.mem_rd_valid) rd_q <= bus.mem_rd_data;
    end

    // Registers that drive outputs are cleared so a reset leaves the memory bus quiet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q    <= '0;
            wr_data_q <= '0;
            be_q      <= '0;
            mis_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= {bus.address[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                be_q   <= req_be;
                mis_q  <= req_mis;
                if (req_full) wr_data_q <= bus.b_out;
            end
            if (state == MERGE) wr_data_q <= merge_word(st_q, rd_q, be_q, ofs_q);
        end
    end

    always_comb begin
        bus.mem_read    = (state == READ);
        bus.mem_write   = (state == WRITE);
        bus.busy        = (state != IDLE);
        bus.done        = (state == DONE);
        bus.misaligned  = (state == DONE) && mis_q;
        bus.byte_enable = (state == WRITE) ? be_q : '0;
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: a 32-bit and a 64-bit instance driven from a vector table
// plus hand sequences for reset during a write, start while busy and back-to-back stores.
module tb_store_merge_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    store_merge_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if32 ();
    store_merge_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if64 ();

    store_merge_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32.slave)
    );

    store_merge_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64.slave)
    );

    typedef struct {
        bit          w64;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] b;
        logic [63:0] rd;
        int          rd_dly;
        int          wr_dly;
        bit          ex_rd;
        bit          ex_wr;
        bit          ex_mis;
        logic [63:0] ex_data;
        logic [7:0]  ex_be;
        logic [31:0] ex_addr;
        int          ex_cyc;
    } vec_t;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          done;
        bit          mis;
        bit          busy;
        logic [63:0] wd;
        logic [7:0]  be;
        logic [31:0] ma;
    } obs_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input bit w64, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [63:0] b, input logic [63:0] rd, input int rd_dly,
                                 input int wr_dly, input bit ex_rd, input bit ex_wr, input bit ex_mis,
                                 input logic [63:0] ex_data, input logic [7:0] ex_be,
                                 input logic [31:0] ex_addr, input int ex_cyc);
        vec_t v;
        v.w64 = w64; v.size = size; v.addr = addr; v.b = b; v.rd = rd;
        v.rd_dly = rd_dly; v.wr_dly = wr_dly;
        v.ex_rd = ex_rd; v.ex_wr = ex_wr; v.ex_mis = ex_mis;
        v.ex_data = ex_data; v.ex_be = ex_be; v.ex_addr = ex_addr; v.ex_cyc = ex_cyc;
        return v;
    endfunction

    function automatic obs_t sample(input bit w64);
        obs_t o;
        if (w64) begin
            o.rd = if64.mem_read; o.wr = if64.mem_write; o.done = if64.done;
            o.mis = if64.misaligned; o.busy = if64.busy;
            o.wd = if64.mem_wr_data; o.be = if64.byte_enable; o.ma = if64.mem_address;
        end else begin
            o.rd = if32.mem_read; o.wr = if32.mem_write; o.done = if32.done;
            o.mis = if32.misaligned; o.busy = if32.busy;
            o.wd = {32'h0, if32.mem_wr_data}; o.be = {4'h0, if32.byte_enable};
            o.ma = if32.mem_address;
        end
        return o;
    endfunction

    task automatic drive_req(input bit w64, input bit st, input logic [1:0] sz,
                             input logic [31:0] a, input logic [63:0] b);
        if (w64) begin
            if64.start = st; if64.store_size = sz; if64.address = a; if64.b_out = b;
        end else begin
            if32.start = st; if32.store_size = sz; if32.address = a; if32.b_out = b[31:0];
        end
    endtask

    task automatic set_mem(input bit w64, input bit rv, input logic [63:0] rdata, input bit rdy);
        if (w64) begin
            if64.mem_rd_valid = rv; if64.mem_rd_data = rdata; if64.mem_wr_ready = rdy;
        end else begin
            if32.mem_rd_valid = rv; if32.mem_rd_data = rdata[31:0]; if32.mem_wr_ready = rdy;
        end
    endtask

    // Called and returns at a negedge; the request is sampled at the following posedge (edge 0).
    task automatic run_vec(input string tag, input vec_t v, input bit poke);
        obs_t o;
        bit saw_rd = 0, saw_wr = 0, got_done = 0, mis = 0, busy1 = 0;
        logic [63:0] wd = '0;
        logic [7:0]  be = '0;
        logic [31:0] ma1 = '0;
        int cyc = 1, rdc = 0, wrc = 0;
        bit rv, rdy;

        drive_req(v.w64, 1'b1, v.size, v.addr, v.b);
        set_mem(v.w64, 1'b0, ~v.rd, 1'b0);
        @(posedge clk);
        #1 drive_req(v.w64, 1'b0, ~v.size, ~v.addr, ~v.b);
        forever begin
            @(negedge clk);
            o = sample(v.w64);
            if (cyc == 1) begin
                ma1 = o.ma;
                busy1 = o.busy;
            end
            rv = 1'b0;
            rdy = 1'b0;
            if (o.rd) begin
                saw_rd = 1;
                rdc++;
                rv = (rdc > v.rd_dly);
            end
            if (o.wr) begin
                saw_wr = 1;
                wrc++;
                rdy = (wrc > v.wr_dly);
                wd = o.wd;
                be = o.be;
            end
            set_mem(v.w64, rv, rv ? v.rd : ~v.rd, rdy);
            if (poke) begin
                if (o.rd && rdc == 1) drive_req(v.w64, 1'b1, 2'b10, 32'h0000_0080, 64'h0);
                else                  drive_req(v.w64, 1'b0, ~v.size, ~v.addr, ~v.b);
            end
            if (o.done) begin
                got_done = 1;
                mis = o.mis;
                break;
            end
            if (cyc >= 40) break;
            @(posedge clk);
            cyc++;
        end
        set_mem(v.w64, 1'b0, ~v.rd, 1'b0);
        chk({tag, ".done_seen"}, 64'(got_done), 64'd1);
        chk({tag, ".done_cycle"}, 64'(cyc), 64'(v.ex_cyc));
        chk({tag, ".misaligned"}, 64'(mis), 64'(v.ex_mis));
        chk({tag, ".read_seen"}, 64'(saw_rd), 64'(v.ex_rd));
        chk({tag, ".write_seen"}, 64'(saw_wr), 64'(v.ex_wr));
        chk({tag, ".mem_address"}, 64'(ma1), 64'(v.ex_addr));
        chk({tag, ".busy_c1"}, 64'(busy1), 64'd1);
        if (v.ex_wr) begin
            chk({tag, ".wr_data"}, wd, v.ex_data);
            chk({tag, ".byte_enable"}, 64'(be), 64'(v.ex_be));
        end
        @(posedge clk);
        @(negedge clk);
        o = sample(v.w64);
        chk({tag, ".busy_after"}, 64'(o.busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int n;

        reset = 1'b0;
        drive_req(1'b0, 1'b0, 2'b00, 32'h0, 64'h0);
        drive_req(1'b1, 1'b0, 2'b00, 32'h0, 64'h0);
        set_mem(1'b0, 1'b0, 64'h0, 1'b0);
        set_mem(1'b1, 1'b0, 64'h0, 1'b0);

        //             w64 sz  addr          b                      rd                     rdd wrd r w m  data                   be     addr          cyc
        vecs[0]  = mkv(0, 2'd0, 32'h103,  64'h0000_00AB,          64'h1122_3344,          0, 0, 1, 1, 0, 64'hAB22_3344,          8'h08, 32'h100,  4);
        vecs[1]  = mkv(0, 2'd1, 32'h202,  64'hFFFF_BEEF,          64'hCAFE_F00D,          3, 0, 1, 1, 0, 64'hBEEF_F00D,          8'h0C, 32'h200,  7);
        vecs[2]  = mkv(0, 2'd2, 32'h040,  64'hDEAD_BEEF,          64'h0,                  0, 0, 0, 1, 0, 64'hDEAD_BEEF,          8'h0F, 32'h040,  2);
        vecs[3]  = mkv(0, 2'd2, 32'h040,  64'hDEAD_BEEF,          64'h0,                  0, 2, 0, 1, 0, 64'hDEAD_BEEF,          8'h0F, 32'h040,  4);
        vecs[4]  = mkv(0, 2'd1, 32'h101,  64'h1234,               64'h0,                  0, 0, 0, 0, 1, 64'h0,                  8'h00, 32'h100,  1);
        vecs[5]  = mkv(0, 2'd2, 32'h102,  64'h1234_5678,          64'h0,                  0, 0, 0, 0, 1, 64'h0,                  8'h00, 32'h100,  1);
        vecs[6]  = mkv(0, 2'd3, 32'h100,  64'h1234_5678,          64'h0,                  0, 0, 0, 0, 1, 64'h0,                  8'h00, 32'h100,  1);
        vecs[7]  = mkv(0, 2'd0, 32'h001,  64'h0000_005A,          64'hFFFF_FFFF,          0, 1, 1, 1, 0, 64'hFFFF_5AFF,          8'h02, 32'h000,  5);
        vecs[8]  = mkv(1, 2'd2, 32'h1004, 64'hFFFF_FFFF_1234_5678, 64'hAAAA_AAAA_BBBB_BBBB, 0, 0, 1, 1, 0, 64'h1234_5678_BBBB_BBBB, 8'hF0, 32'h1000, 4);
        vecs[9]  = mkv(1, 2'd3, 32'h1008, 64'h0123_4567_89AB_CDEF, 64'h0,                  0, 0, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'h1008, 2);
        vecs[10] = mkv(1, 2'd0, 32'h1007, 64'h77,                 64'h0,                  1, 0, 1, 1, 0, 64'h7700_0000_0000_0000, 8'h80, 32'h1000, 5);
        vecs[11] = mkv(1, 2'd1, 32'h1002, 64'hCDEF,               64'h1111_1111_1111_1111, 0, 0, 1, 1, 0, 64'h1111_1111_CDEF_1111, 8'h0C, 32'h1000, 4);
        vecs[12] = mkv(1, 2'd1, 32'h1003, 64'hCDEF,               64'h0,                  0, 0, 0, 0, 1, 64'h0,                  8'h00, 32'h1000, 1);
        vecs[13] = mkv(1, 2'd2, 32'h1002, 64'h1234_5678,          64'h0,                  0, 0, 0, 0, 1, 64'h0,                  8'h00, 32'h1000, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            o = sample(w[0]);
            chk($sformatf("rst%0d.mem_read", w), 64'(o.rd), 64'd0);
            chk($sformatf("rst%0d.mem_write", w), 64'(o.wr), 64'd0);
            chk($sformatf("rst%0d.busy", w), 64'(o.busy), 64'd0);
            chk($sformatf("rst%0d.done", w), 64'(o.done), 64'd0);
            chk($sformatf("rst%0d.misaligned", w), 64'(o.mis), 64'd0);
            chk($sformatf("rst%0d.byte_enable", w), 64'(o.be), 64'd0);
            chk($sformatf("rst%0d.mem_wr_data", w), o.wd, 64'd0);
            chk($sformatf("rst%0d.mem_address", w), 64'(o.ma), 64'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < NV; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

        // start pulsed during READ must not disturb the store in flight nor queue a new one
        run_vec("poke", vecs[0], 1'b1);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.busy) n++;
        end
        chk("poke.no_queued_store", 64'(n), 64'd0);

        // back-to-back stores on the 32-bit unit
        run_vec("b2b_a", mkv(0, 2'd0, 32'h002, 64'h99, 64'h0102_0304, 0, 0, 1, 1, 0,
                             64'h0199_0304, 8'h04, 32'h000, 4), 1'b0);
        run_vec("b2b_b", mkv(0, 2'd1, 32'h000, 64'h7788, 64'hAABB_CCDD, 0, 0, 1, 1, 0,
                             64'hAABB_7788, 8'h03, 32'h000, 4), 1'b0);

        // reset asserted while a word write is stalled
        drive_req(1'b0, 1'b1, 2'b10, 32'h40, 64'hDEAD_BEEF);
        set_mem(1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk);
        #1 drive_req(1'b0, 1'b0, 2'b00, 32'h0, 64'h0);
        @(negedge clk);
        o = sample(1'b0);
        chk("rstw.in_write", 64'(o.wr), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        o = sample(1'b0);
        chk("rstw.mem_read", 64'(o.rd), 64'd0);
        chk("rstw.mem_write", 64'(o.wr), 64'd0);
        chk("rstw.busy", 64'(o.busy), 64'd0);
        chk("rstw.done", 64'(o.done), 64'd0);
        chk("rstw.misaligned", 64'(o.mis), 64'd0);
        chk("rstw.byte_enable", 64'(o.be), 64'd0);
        chk("rstw.mem_wr_data", o.wd, 64'd0);
        chk("rstw.mem_address", 64'(o.ma), 64'd0);
        set_mem(1'b0, 1'b0, 64'h0, 1'b1);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.done || o.wr) n++;
        end
        set_mem(1'b0, 1'b0, 64'h0, 1'b0);
        chk("rstw.no_done", 64'(n), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Parametrised store path for the multicycle datapath. It replaces the combinational byte/half/word splice with a sequenced read-modify-write engine. For sub-word stores it fetches the containing memory word, merges the store data into the byte lanes selected by the address offset, and writes the word back. Full-width stores go straight to a write. It sits between the B register / address path and the data memory port, and the control unit starts it and waits for `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: memory word width. Legal values are 32 and 64.
- `ADDR_WIDTH`, 32: byte address width.
- `BYTES`, derived as DATA_WIDTH/8. `OFS` = log2(BYTES).

Ports (reset is synchronous and active-low, on the single clock `clk`):
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: request a store. Sampled only in IDLE.
- `store_size` in 2: 00 byte, 01 half, 10 word (32b), 11 double. 11 is legal only when DATA_WIDTH=64.
- `address` in ADDR_WIDTH: byte address of the store.
- `b_out` in DATA_WIDTH: store data, right-justified.
- `mem_rd_data` in DATA_WIDTH: read data from memory.
- `mem_rd_valid` in 1: `mem_rd_data` is valid this cycle.
- `mem_wr_ready` in 1: memory accepts the write this cycle.
- `mem_address` out ADDR_WIDTH: `address` with its low OFS bits forced to 0.
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `mem_wr_data` out DATA_WIDTH: merged write word.
- `byte_enable` out BYTES: lanes being written.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: valid only while `done` is high.

## Operation
- On `start` in IDLE, latch `address`, `store_size` and `b_out`. Compute these values from the latched copies:
  - size bytes `n`: 1, 2, 4 or 8.
  - lane offset `o` = address[OFS-1:0].
- A store is misaligned if `o` is not a multiple of `n`, or if `store_size`=11 with DATA_WIDTH=32.
- Merge rule: for lane k, if o ≤ k < o+n, take byte (k−o) of the latched `b_out`. Otherwise take byte k of the captured `mem_rd_data`.
- `byte_enable` has bit k set for o ≤ k < o+n.
- A store is full-width when n = BYTES. In that case `mem_wr_data` = latched `b_out` and no read is issued.
- State machine:
  - IDLE: on `start`:
    - misaligned → DONE;
    - else full-width → WRITE;
    - else → READ.
  - READ: `mem_read`=1. Hold until `mem_rd_valid`, then capture `mem_rd_data` and go to MERGE.
  - MERGE: register the merged word into `mem_wr_data`, then go to WRITE.
  - WRITE: `mem_write`=1 with `mem_wr_data` and `byte_enable` stable. Hold until `mem_wr_ready`, then go to DONE.
  - DONE: `done`=1. `misaligned` is 1 if this is an aborted store. Then go to IDLE.
- Misaligned stores never assert `mem_read` or `mem_write`.
- `start` outside IDLE is ignored. It is neither queued nor allowed to change the latched operands.
- `mem_rd_valid` outside READ and `mem_wr_ready` outside WRITE are ignored.

## Timing
- Reset (`reset`=0 at a rising edge) forces IDLE from any state, including mid-READ or mid-WRITE. After that edge:
  - `mem_read`, `mem_write`, `busy`, `done`, `misaligned` = 0;
  - `byte_enable` = 0;
  - `mem_wr_data` and `mem_address` = 0.
- A store aborted by reset produces no `done`.
- All outputs are registered or decoded from state only. There is no combinational path from memory inputs to outputs.
- Cycle numbering: `start` is sampled at edge 0.
- Sub-word store, with `mem_rd_valid` in the first READ cycle and `mem_wr_ready` in the first WRITE cycle:
  - READ in cycle 1, MERGE in cycle 2, WRITE in cycle 3, DONE in cycle 4.
  - Total 4 cycles. Each wait cycle adds 1.
- Full-width store: WRITE in cycle 1, DONE in cycle 2.
- Misaligned store: DONE in cycle 1.
- `busy` rises in cycle 1 and falls when the FSM returns to IDLE, in the cycle after DONE.
- A new `start` is accepted in the first IDLE cycle after DONE (back-to-back allowed).
- `mem_address` is valid from cycle 1 until IDLE.

## Test plan
1. DATA_WIDTH=32, byte store:
   - Stimulus: address=0x103, b_out=0x000000AB, mem_rd_data=0x11223344.
   - Required: mem_read in cycle 1, then mem_write with mem_address=0x100, mem_wr_data=0xAB223344, byte_enable=1000, then done in cycle 4.
2. DATA_WIDTH=32, half store:
   - Stimulus: address=0x202, b_out=0xFFFFBEEF, rd=0xCAFEF00D, with mem_rd_valid delayed 3 cycles.
   - Required: mem_wr_data=0xBEEFF00D, byte_enable=1100, done in cycle 7.
3. Word store:
   - Stimulus: address=0x40, b_out=0xDEADBEEF.
   - Required: no mem_read, mem_write in cycle 1, done in cycle 2.
   - Repeat with mem_wr_ready held low 2 cycles → done in cycle 4.
4. Misaligned stores:
   - Half at 0x101, or word at 0x102 → done and misaligned in cycle 1, with no memory strobe.
   - store_size=11 with DATA_WIDTH=32 → same response.
5. DATA_WIDTH=64:
   - Word store at 0x1004, b_out=0x…12345678, rd=0xAAAAAAAABBBBBBBB → mem_wr_data=0x12345678BBBBBBBB, byte_enable=0xF0.
   - Double store at 0x1008 → no read, direct write.
6. Reset and start handling:
   - Drive reset=0 during WRITE → next cycle all outputs are 0 and no done is produced.
   - Pulse start in READ → ignored.
   - Two back-to-back stores both complete with correct data.
